// File: rtl/mp3_pkg.sv
// Shared types for the MP3 PCM output receiver: framing state and default word width.
package mp3_pkg;

    localparam int MP3_SAMPLE_BITS = 16;

    typedef enum logic [1:0] {
        SYNC_WAIT,
        LEFT,
        RIGHT
    } rx_state_e;

endpackage

// File: rtl/mp3_input_sync.sv
// Multi-flop synchronizer for a bus of asynchronous pins, with a rising-edge
// detect on every bit taken from one extra flop behind the chain.
module mp3_input_sync
    import mp3_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
    logic [WIDTH-1:0]             dly_q, dly_d;

    always_comb begin
        chain_d[0] = async_in;
        for (int i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
        dly_d = chain_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
            dly_q   <= '0;
        end else begin
            chain_q <= chain_d;
            dly_q   <= dly_d;
        end
    end

    assign sync_out = chain_q[STAGES-1];
    assign rise     = chain_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/mp3_sample_receiver.sv
// Deserializes the decoder's PCM stream (LRCK high = left, toggling with the first
// BCLK of a word) into stereo pairs. Peak metering enabled by MP3_SAMPLE_RECEIVER_PEAK_EN.
module mp3_sample_receiver
    import mp3_pkg::*;
#(
    parameter int SAMPLE_BITS = MP3_SAMPLE_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   i2sBitClk,
    input  logic                   i2sWordClk,
    input  logic                   i2sData,
    output logic [SAMPLE_BITS-1:0] sampleL,
    output logic [SAMPLE_BITS-1:0] sampleR,
    output logic                   sampleValid,
    input  logic                   sampleAck,
    output logic                   overrun,
    output logic                   lengthError,
    input  logic                   flagsClear,
    output logic [SAMPLE_BITS-1:0] peakL,
    output logic [SAMPLE_BITS-1:0] peakR,
    input  logic                   peakClear
);

    localparam int CW = $clog2(SAMPLE_BITS + 1);
    localparam logic [CW-1:0] FULL = CW'(SAMPLE_BITS);

    logic [2:0] sync_bus, rise_bus;

    mp3_input_sync #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in ({i2sBitClk, i2sWordClk, i2sData}),
        .sync_out (sync_bus),
        .rise     (rise_bus)
    );

    rx_state_e              state_q, state_d;
    logic                   cap_vld_q, cap_vld_d, cap_lrck_q, cap_lrck_d, cap_data_q, cap_data_d;
    logic                   prev_lrck_q, prev_lrck_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d, left_hold_q, left_hold_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SAMPLE_BITS-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic                   pub_q, pub_d;
    logic [SAMPLE_BITS-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
    logic                   valid_q, valid_d, overrun_q, overrun_d, len_err_q, len_err_d;
    logic                   boundary, word_ok, len_err_set;

    always_comb begin
        cap_vld_d   = rise_bus[2];
        cap_lrck_d  = sync_bus[1];
        cap_data_d  = sync_bus[0];
        state_d     = state_q;
        prev_lrck_d = prev_lrck_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        left_hold_d = left_hold_q;
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        pub_d       = 1'b0;
        len_err_set = 1'b0;
        boundary    = cap_lrck_q != prev_lrck_q;
        word_ok     = cnt_q == FULL;

        if (cap_vld_q) begin
            prev_lrck_d = cap_lrck_q;
            shift_d     = {shift_q[SAMPLE_BITS-2:0], cap_data_q};
            if (boundary)           cnt_d = CW'(1);
            else if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;

            // shift_q still holds the word that this boundary edge completes
            if (boundary) begin
                case (state_q)
                    SYNC_WAIT: if (cap_lrck_q) state_d = LEFT;
                    LEFT: begin
                        if (word_ok) begin
                            left_hold_d = shift_q;
                            state_d     = RIGHT;
                        end else begin
                            len_err_set = 1'b1;
                            state_d     = SYNC_WAIT;
                        end
                    end
                    RIGHT: begin
                        if (word_ok) begin
                            pend_l_d = left_hold_q;
                            pend_r_d = shift_q;
                            pub_d    = 1'b1;
                        end else begin
                            len_err_set = 1'b1;
                        end
                        state_d = LEFT;
                    end
                    default: state_d = SYNC_WAIT;
                endcase
            end
        end

        if (!enable) begin
            state_d     = SYNC_WAIT;
            cnt_d       = '0;
            pub_d       = 1'b0;
            len_err_set = 1'b0;
        end

        sample_l_d = sample_l_q;
        sample_r_d = sample_r_q;
        valid_d    = valid_q;
        if (pub_q) begin
            sample_l_d = pend_l_q;
            sample_r_d = pend_r_q;
            valid_d    = 1'b1;
        end else if (sampleAck) begin
            valid_d = 1'b0;
        end
        overrun_d = (pub_q & valid_q & ~sampleAck) | (overrun_q & ~flagsClear);
        len_err_d = len_err_set | (len_err_q & ~flagsClear);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SYNC_WAIT;
            cap_vld_q   <= 1'b0;
            cap_lrck_q  <= 1'b0;
            cap_data_q  <= 1'b0;
            prev_lrck_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            left_hold_q <= '0;
            pend_l_q    <= '0;
            pend_r_q    <= '0;
            pub_q       <= 1'b0;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_vld_q   <= cap_vld_d;
            cap_lrck_q  <= cap_lrck_d;
            cap_data_q  <= cap_data_d;
            prev_lrck_q <= prev_lrck_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            left_hold_q <= left_hold_d;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            pub_q       <= pub_d;
            sample_l_q  <= sample_l_d;
            sample_r_q  <= sample_r_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            len_err_q   <= len_err_d;
        end
    end

    assign sampleL     = sample_l_q;
    assign sampleR     = sample_r_q;
    assign sampleValid = valid_q;
    assign overrun     = overrun_q;
    assign lengthError = len_err_q;

`ifdef MP3_SAMPLE_RECEIVER_PEAK_EN
    function automatic logic [SAMPLE_BITS-1:0] magnitude(input logic [SAMPLE_BITS-1:0] w);
        return w[SAMPLE_BITS-1] ? (~w + 1'b1) : w;
    endfunction

    logic [SAMPLE_BITS-1:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d, mag_l, mag_r;

    always_comb begin
        mag_l    = magnitude(pend_l_q);
        mag_r    = magnitude(pend_r_q);
        peak_l_d = peak_l_q;
        peak_r_d = peak_r_q;
        if (pub_q) begin
            peak_l_d = (peakClear || mag_l > peak_l_q) ? mag_l : peak_l_q;
            peak_r_d = (peakClear || mag_r > peak_r_q) ? mag_r : peak_r_q;
        end else if (peakClear) begin
            peak_l_d = '0;
            peak_r_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else begin
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
        end
    end

    assign peakL = peak_l_q;
    assign peakR = peak_r_q;
`else
    logic unused_peak_clear;
    assign unused_peak_clear = peakClear;
    assign peakL = '0;
    assign peakR = '0;
`endif

endmodule
